// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: issues one fetch at a time on an SRAM-like port and
// presents {pc, inst, adel} to decode through a valid/allowin handshake.
//
// state     | meaning
// ----------|-----------------------------------------------------------
// S_REQ     | requesting pc (or raising address error if pc misaligned)
// S_WAIT    | address accepted, waiting for read data (discard = drop it)
// S_VALID   | entry presented to decode, held until allowin or flush
module if_fetch_stage #(
   parameter logic [31:0] NOP_INST = 32'h00000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc,
   output logic        pc_en,
   input  logic        flush,
   output logic        inst_req,
   output logic [31:0] inst_addr,
   input  logic        inst_addr_ok,
   input  logic        inst_data_ok,
   input  logic [31:0] inst_rdata,
   output logic        fs_valid,
   output logic [31:0] fs_pc,
   output logic [31:0] fs_inst,
   output logic        fs_adel,
   input  logic        ds_allowin
);

   typedef enum logic [1:0] {
      S_REQ   = 2'd0,
      S_WAIT  = 2'd1,
      S_VALID = 2'd2
   } state_t;

   state_t      state;
   logic        discard;
   logic [31:0] fetch_pc;
   logic        pc_misaligned;
   logic        addr_accept;

   assign pc_misaligned = (pc[1:0] != 2'b00);
   assign inst_req      = (state == S_REQ) && !pc_misaligned && !reset;
   assign inst_addr     = pc;
   assign addr_accept   = inst_req && inst_addr_ok;

   // A misaligned pc is consumed without a memory request, so it advances the PC too.
   assign pc_en = !reset && (flush || addr_accept || ((state == S_REQ) && pc_misaligned));

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_REQ;
         discard  <= 1'b0;
         fetch_pc <= 32'h0;
         fs_valid <= 1'b0;
         fs_pc    <= 32'h0;
         fs_inst  <= 32'h0;
         fs_adel  <= 1'b0;
      end else begin
         case (state)
            S_REQ: begin
               if (addr_accept) begin
                  fetch_pc <= pc;
                  discard  <= flush;
                  state    <= S_WAIT;
               end else if (pc_misaligned && !flush) begin
                  fs_valid <= 1'b1;
                  fs_pc    <= pc;
                  fs_inst  <= NOP_INST;
                  fs_adel  <= 1'b1;
                  state    <= S_VALID;
               end
            end
            S_WAIT: begin
               if (inst_data_ok) begin
                  if (discard || flush) begin
                     discard <= 1'b0;
                     state   <= S_REQ;
                  end else begin
                     fs_valid <= 1'b1;
                     fs_pc    <= fetch_pc;
                     fs_inst  <= inst_rdata;
                     fs_adel  <= 1'b0;
                     state    <= S_VALID;
                  end
               end else if (flush) begin
                  discard <= 1'b1;
               end
            end
            S_VALID: begin
               // flush and allowin both retire the entry; outputs otherwise hold
               if (flush || ds_allowin) begin
                  fs_valid <= 1'b0;
                  state    <= S_REQ;
               end
            end
            default: state <= S_REQ;
         endcase
      end
   end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed scenarios with inline checks
// plus a scoreboard of expected {pc, inst, adel} entries checked as fs_valid rises.
module tb_if_fetch_stage;

   localparam logic [31:0] NOP = 32'h00000000;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] pc;
   logic        pc_en;
   logic        flush;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok;
   logic        inst_data_ok;
   logic [31:0] inst_rdata;
   logic        fs_valid;
   logic [31:0] fs_pc;
   logic [31:0] fs_inst;
   logic        fs_adel;
   logic        ds_allowin;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [64:0] exp_q[$];
   logic        fs_valid_q;

   if_fetch_stage #(.NOP_INST(NOP)) dut (
      .clk          (clk),
      .reset        (reset),
      .pc           (pc),
      .pc_en        (pc_en),
      .flush        (flush),
      .inst_req     (inst_req),
      .inst_addr    (inst_addr),
      .inst_addr_ok (inst_addr_ok),
      .inst_data_ok (inst_data_ok),
      .inst_rdata   (inst_rdata),
      .fs_valid     (fs_valid),
      .fs_pc        (fs_pc),
      .fs_inst      (fs_inst),
      .fs_adel      (fs_adel),
      .ds_allowin   (ds_allowin)
   );

   always #5 clk = ~clk;

   // scoreboard: every new presented entry must match the oldest expectation
   always @(negedge clk) begin
      if (fs_valid === 1'b1 && fs_valid_q !== 1'b1) begin
         tests_run++;
         if (exp_q.size() == 0) begin
            tests_failed++;
            $display("FAIL sb_unexpected_entry: got pc=%h inst=%h adel=%b, none expected",
                     fs_pc, fs_inst, fs_adel);
         end else begin
            logic [64:0] e;
            e = exp_q.pop_front();
            if ({fs_pc, fs_inst, fs_adel} !== e) begin
               tests_failed++;
               $display("FAIL sb_entry: got pc=%h inst=%h adel=%b, want pc=%h inst=%h adel=%b",
                        fs_pc, fs_inst, fs_adel, e[64:33], e[32:1], e[0]);
            end
         end
      end
      fs_valid_q = fs_valid;
   end

   // advance to just after the next rising edge
   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; pc = 32'hbfc00000; flush = 1'b0;
      inst_addr_ok = 1'b1; inst_data_ok = 1'b1; inst_rdata = 32'h12345678; ds_allowin = 1'b1;
      next();
      for (int i = 0; i < 2; i++) begin
         #1;
         tests_run++;
         if (inst_req !== 1'b0 || pc_en !== 1'b0 || fs_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_hold[%0d]: got req=%b pc_en=%b valid=%b, want 0 0 0",
                     i, inst_req, pc_en, fs_valid);
         end
         next();
      end
      reset = 1'b0; inst_addr_ok = 1'b0; inst_data_ok = 1'b0;
      #1;
      tests_run++;
      if (inst_req !== 1'b1 || inst_addr !== 32'hbfc00000 || pc_en !== 1'b0 ||
          fs_valid !== 1'b0 || fs_pc !== 32'h0 || fs_inst !== 32'h0 || fs_adel !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_release: got req=%b addr=%h pc_en=%b valid=%b pc=%h inst=%h adel=%b",
                  inst_req, inst_addr, pc_en, fs_valid, fs_pc, fs_inst, fs_adel);
      end
      next();
   endtask

   task automatic test_zero_wait();
      pc = 32'hbfc00000; inst_addr_ok = 1'b1; ds_allowin = 1'b1;
      #1;
      tests_run++;
      if (pc_en !== 1'b1 || inst_req !== 1'b1) begin
         tests_failed++;
         $display("FAIL zw_c0: got pc_en=%b req=%b, want 1 1", pc_en, inst_req);
      end
      next();
      inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h3c08bfc0; pc = 32'hbfc00004;
      exp_q.push_back({32'hbfc00000, 32'h3c08bfc0, 1'b0});
      #1;
      tests_run++;
      if (pc_en !== 1'b0 || inst_req !== 1'b0) begin
         tests_failed++;
         $display("FAIL zw_c1: got pc_en=%b req=%b, want 0 0", pc_en, inst_req);
      end
      next();
      inst_data_ok = 1'b0;
      #1;
      tests_run++;
      if (fs_valid !== 1'b1 || fs_pc !== 32'hbfc00000 || fs_inst !== 32'h3c08bfc0 ||
          fs_adel !== 1'b0 || pc_en !== 1'b0) begin
         tests_failed++;
         $display("FAIL zw_c2: got valid=%b pc=%h inst=%h adel=%b pc_en=%b, want 1 bfc00000 3c08bfc0 0 0",
                  fs_valid, fs_pc, fs_inst, fs_adel, pc_en);
      end
      next();
      #1;
      tests_run++;
      if (inst_req !== 1'b1 || fs_valid !== 1'b0 || inst_addr !== 32'hbfc00004) begin
         tests_failed++;
         $display("FAIL zw_c3: got req=%b valid=%b addr=%h, want 1 0 bfc00004",
                  inst_req, fs_valid, inst_addr);
      end
   endtask

   task automatic test_backpressure();
      pc = 32'hbfc00004; inst_addr_ok = 1'b1; ds_allowin = 1'b0;
      next();
      inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h24080001; pc = 32'hbfc00008;
      exp_q.push_back({32'hbfc00004, 32'h24080001, 1'b0});
      next();
      inst_data_ok = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         tests_run++;
         if (fs_valid !== 1'b1 || fs_pc !== 32'hbfc00004 || fs_inst !== 32'h24080001 ||
             inst_req !== 1'b0 || pc_en !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_hold[%0d]: got valid=%b pc=%h inst=%h req=%b pc_en=%b",
                     i, fs_valid, fs_pc, fs_inst, inst_req, pc_en);
         end
         next();
      end
      ds_allowin = 1'b1;
      next();
      #1;
      tests_run++;
      if (fs_valid !== 1'b0 || inst_req !== 1'b1) begin
         tests_failed++;
         $display("FAIL bp_release: got valid=%b req=%b, want 0 1", fs_valid, inst_req);
      end
   endtask

   task automatic test_flush_wait();
      pc = 32'hbfc00008; inst_addr_ok = 1'b1;
      next();
      pc = 32'hbfc0000c; inst_addr_ok = 1'b0;
      #1;
      tests_run++;
      if (pc_en !== 1'b0) begin
         tests_failed++;
         $display("FAIL fw_c1: got pc_en=%b, want 0", pc_en);
      end
      next();
      flush = 1'b1;
      #1;
      tests_run++;
      if (pc_en !== 1'b1) begin
         tests_failed++;
         $display("FAIL fw_c2: got pc_en=%b, want 1", pc_en);
      end
      next();
      flush = 1'b0; pc = 32'hbfc00380;
      #1;
      tests_run++;
      if (inst_req !== 1'b0 || pc_en !== 1'b0) begin
         tests_failed++;
         $display("FAIL fw_c3: got req=%b pc_en=%b, want 0 0", inst_req, pc_en);
      end
      next();
      inst_data_ok = 1'b1; inst_rdata = 32'hdeadbeef;
      #1;
      tests_run++;
      if (pc_en !== 1'b0) begin
         tests_failed++;
         $display("FAIL fw_c4: got pc_en=%b, want 0", pc_en);
      end
      next();
      inst_data_ok = 1'b0;
      #1;
      tests_run++;
      if (inst_req !== 1'b1 || inst_addr !== 32'hbfc00380 || fs_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL fw_c5: got req=%b addr=%h valid=%b, want 1 bfc00380 0",
                  inst_req, inst_addr, fs_valid);
      end
   endtask

   task automatic test_flush_accept();
      pc = 32'hbfc00380; flush = 1'b1; inst_addr_ok = 1'b1;
      #1;
      tests_run++;
      if (pc_en !== 1'b1) begin
         tests_failed++;
         $display("FAIL fa_c0: got pc_en=%b, want 1", pc_en);
      end
      next();
      flush = 1'b0; inst_addr_ok = 1'b0; pc = 32'hbfc00100;
      inst_data_ok = 1'b1; inst_rdata = 32'hdeadbeef;
      #1;
      tests_run++;
      if (pc_en !== 1'b0 || inst_req !== 1'b0) begin
         tests_failed++;
         $display("FAIL fa_c1: got pc_en=%b req=%b, want 0 0", pc_en, inst_req);
      end
      next();
      inst_data_ok = 1'b0;
      #1;
      tests_run++;
      if (fs_valid !== 1'b0 || inst_req !== 1'b1 || inst_addr !== 32'hbfc00100) begin
         tests_failed++;
         $display("FAIL fa_c2: got valid=%b req=%b addr=%h, want 0 1 bfc00100",
                  fs_valid, inst_req, inst_addr);
      end
      inst_addr_ok = 1'b1;
      next();
      inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h8c090000; pc = 32'hbfc00104;
      exp_q.push_back({32'hbfc00100, 32'h8c090000, 1'b0});
      next();
      inst_data_ok = 1'b0;
      #1;
      tests_run++;
      if (fs_valid !== 1'b1 || fs_pc !== 32'hbfc00100 || fs_inst !== 32'h8c090000) begin
         tests_failed++;
         $display("FAIL fa_redirect: got valid=%b pc=%h inst=%h, want 1 bfc00100 8c090000",
                  fs_valid, fs_pc, fs_inst);
      end
      next();
   endtask

   // data_ok and flush together drop the data but must not leave discard set
   task automatic test_flush_data_same_cycle();
      pc = 32'hbfc00104; inst_addr_ok = 1'b1;
      next();
      inst_addr_ok = 1'b0; pc = 32'hbfc00108;
      flush = 1'b1; inst_data_ok = 1'b1; inst_rdata = 32'h11111111;
      #1;
      tests_run++;
      if (pc_en !== 1'b1) begin
         tests_failed++;
         $display("FAIL fd_c1: got pc_en=%b, want 1", pc_en);
      end
      next();
      flush = 1'b0; inst_data_ok = 1'b0; pc = 32'hbfc00200;
      #1;
      tests_run++;
      if (inst_req !== 1'b1 || inst_addr !== 32'hbfc00200 || fs_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL fd_c2: got req=%b addr=%h valid=%b, want 1 bfc00200 0",
                  inst_req, inst_addr, fs_valid);
      end
      inst_addr_ok = 1'b1;
      next();
      inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h00851021; pc = 32'hbfc00204;
      exp_q.push_back({32'hbfc00200, 32'h00851021, 1'b0});
      next();
      inst_data_ok = 1'b0;
      next();
   endtask

   task automatic test_misaligned();
      pc = 32'hbfc00002;
      exp_q.push_back({32'hbfc00002, NOP, 1'b1});
      #1;
      tests_run++;
      if (inst_req !== 1'b0 || pc_en !== 1'b1) begin
         tests_failed++;
         $display("FAIL ma_c0: got req=%b pc_en=%b, want 0 1", inst_req, pc_en);
      end
      next();
      pc = 32'hbfc00000;
      #1;
      tests_run++;
      if (fs_valid !== 1'b1 || fs_adel !== 1'b1 || fs_inst !== NOP ||
          fs_pc !== 32'hbfc00002 || pc_en !== 1'b0) begin
         tests_failed++;
         $display("FAIL ma_c1: got valid=%b adel=%b inst=%h pc=%h pc_en=%b, want 1 1 %h bfc00002 0",
                  fs_valid, fs_adel, fs_inst, fs_pc, pc_en, NOP);
      end
      next();
      #1;
      tests_run++;
      if (fs_valid !== 1'b0 || inst_req !== 1'b1) begin
         tests_failed++;
         $display("FAIL ma_c2: got valid=%b req=%b, want 0 1", fs_valid, inst_req);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] d;
      int          wait_cycles;
      int          pc_en_count;
      pc = 32'hbfc00400; ds_allowin = 1'b1;
      for (int i = 0; i < 6; i++) begin
         pc_en_count = 0;
         inst_addr_ok = 1'b1;
         #1;
         if (pc_en === 1'b1) pc_en_count++;
         next();
         inst_addr_ok = 1'b0;
         wait_cycles = $urandom_range(0, 3);
         for (int w = 0; w < wait_cycles; w++) begin
            #1;
            if (pc_en === 1'b1) pc_en_count++;
            next();
         end
         d = $urandom();
         inst_data_ok = 1'b1; inst_rdata = d;
         exp_q.push_back({pc, d, 1'b0});
         #1;
         if (pc_en === 1'b1) pc_en_count++;
         next();
         inst_data_ok = 1'b0;
         pc = pc + 32'd4;
         #1;
         if (pc_en === 1'b1) pc_en_count++;
         next();
         tests_run++;
         if (pc_en_count != 1) begin
            tests_failed++;
            $display("FAIL b2b_pc_en[%0d]: got %0d pulses, want 1", i, pc_en_count);
         end
      end
   endtask

   initial begin
      test_reset();
      test_zero_wait();
      test_backpressure();
      test_flush_wait();
      test_flush_accept();
      test_flush_data_same_cycle();
      test_misaligned();
      test_back_to_back();
      next();
      next();
      tests_run++;
      if (exp_q.size() != 0) begin
         tests_failed++;
         $display("FAIL sb_drain: got %0d entries never presented, want 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage directly downstream of the PC register.
- Takes the current PC and issues one fetch at a time on an SRAM-like instruction port, with separate address and data handshakes.
- Presents {pc, inst, adel} to decode through a valid/allowin handshake.
- Generates pc_en back to the PC register: pulsed when a fetch address is accepted or a redirect occurs. A redirect discards any in-flight fetch.

Parameters:
- NOP_INST, 32'h00000000, instruction word presented for a misaligned (address-error) fetch.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- pc  in  32  current PC from the PC register.
- pc_en  out  1  PC advance enable to the PC register (combinational).
- flush  in  1  redirect (branch/exception/eret) this cycle; the PC register consumes its new target when pc_en=1.
- inst_req  out  1  fetch request valid.
- inst_addr  out  32  fetch address; equals pc.
- inst_addr_ok  in  1  address accepted this cycle (when inst_req=1).
- inst_data_ok  in  1  read data returned this cycle.
- inst_rdata  in  32  returned instruction.
- fs_valid  out  1  fetched instruction valid to decode.
- fs_pc  out  32  PC of the presented instruction.
- fs_inst  out  32  presented instruction.
- fs_adel  out  1  presented entry has an instruction address error (pc[1:0]!=0).
- ds_allowin  in  1  decode accepts the presented entry this cycle.

Behaviour:
- States: REQ, WAIT_DATA, VALID. One internal flag: discard.
- Reset (synchronous, on a clk edge with reset=1):
  - state=REQ, discard=0.
  - fs_valid=0, fs_pc=0, fs_inst=0, fs_adel=0.
  - Reset overrides flush and every handshake.
- Combinational outputs:
  - inst_req = (state==REQ) && (pc[1:0]==0) && !reset.
  - inst_addr = pc.
  - pc_en = !reset && (flush || (inst_req && inst_addr_ok) || (state==REQ && pc[1:0]!=0)).
  - pc_en is 1 for exactly one cycle per accepted fetch, per redirect, and per address error.
- REQ:
  - Accept (inst_req && inst_addr_ok): latch fetch_pc=pc, go to WAIT_DATA. If flush is high in the same cycle, set discard=1.
  - Misaligned pc, no flush: next cycle fs_valid=1, fs_pc=pc, fs_inst=NOP_INST, fs_adel=1; go to VALID. No memory request is issued.
  - Flush without accept: stay in REQ. pc_en=1 loads the target, and the next cycle requests the new pc.
  - The address may change while inst_req is high and not yet accepted.
- WAIT_DATA:
  - On inst_data_ok with discard=1: drop the data, clear discard, go to REQ.
  - On inst_data_ok with discard=0 and no flush: fs_valid=1, fs_pc=fetch_pc, fs_inst=inst_rdata, fs_adel=0; go to VALID.
  - inst_data_ok and flush in the same cycle: drop the data, discard stays 0, go to REQ.
  - Flush without data_ok: set discard=1, stay in WAIT_DATA.
  - At most one fetch is outstanding. inst_data_ok outside WAIT_DATA is ignored.
- VALID:
  - Outputs are held stable until the handshake completes.
  - ds_allowin=1: next cycle fs_valid=0, go to REQ.
  - flush: fs_valid=0 next cycle, go to REQ. Flush has priority over ds_allowin, and the entry is not considered consumed.
- Latency: addr_ok in cycle N, data_ok in cycle M ≥ N+1 → fs_valid in cycle M+1.
- Peak throughput: one instruction per 3 cycles (REQ, WAIT_DATA, VALID with immediate allowin).
- Reset mid-fetch: the state machine returns to REQ with discard=0. The memory side is reset concurrently and returns no stale data_ok.

Test Plan:
- Reset held 2 cycles with pc=32'hbfc00000, addr_ok=1, data_ok=1 → inst_req=0, pc_en=0, fs_valid=0 throughout. Release → inst_req=1, inst_addr=32'hbfc00000 the same cycle.
- Zero-wait fetch: pc=32'hbfc00000, addr_ok=1 (cycle 0), data_ok=1 with rdata=32'h3c08bfc0 (cycle 1), ds_allowin=1 → pc_en=1 only in cycle 0; fs_valid=1, fs_pc=32'hbfc00000, fs_inst=32'h3c08bfc0 in cycle 2; inst_req=1 again in cycle 3.
- Backpressure: ds_allowin=0 for 5 cycles after fs_valid → fs_valid, fs_pc, fs_inst stable, inst_req=0, pc_en=0. ds_allowin=1 → fs_valid=0 next cycle.
- Flush while waiting for data: addr_ok at cycle 0, flush at cycle 2, data_ok at cycle 4 with rdata=32'hdeadbeef → pc_en=1 in cycle 2; fs_valid never set for 32'hdeadbeef; new request issued at cycle 5.
- Flush coincident with accept: flush=1 and addr_ok=1 in the same cycle → single pc_en pulse; returned data discarded; next request uses the redirected pc.
- Misaligned pc=32'hbfc00002 → inst_req=0, pc_en=1 for one cycle; next cycle fs_valid=1, fs_adel=1, fs_inst=NOP_INST, fs_pc=32'hbfc00002.
